// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: SX / ZX / shifted-SX / upper placement, with a
// one-deep skid buffer so in_ready is a pure register output.
module imm_ext_pipe #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter int SHIFT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  if (IN_W < 1 || IN_W >= OUT_W || SHIFT < 0 || SHIFT > OUT_W - IN_W) begin : g_param_check
    $error("imm_ext_pipe: illegal IN_W/OUT_W/SHIFT combination");
  end

  localparam logic [1:0] MODE_SX  = 2'b00;
  localparam logic [1:0] MODE_ZX  = 2'b01;
  localparam logic [1:0] MODE_SXS = 2'b10;
  localparam logic [1:0] MODE_UP  = 2'b11;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0]      mode);
    logic signed [OUT_W-1:0] sx;
    logic        [OUT_W-1:0] res;
    sx  = signed'({{(OUT_W-IN_W){imm[IN_W-1]}}, imm});
    res = '0;
    case (mode)
      MODE_SX:  res = unsigned'(sx);
      MODE_ZX:  res = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_SXS: res = unsigned'(sx <<< SHIFT);
      MODE_UP:  res = {imm, {(OUT_W-IN_W){1'b0}}};
      default:  res = '0;
    endcase
    return res;
  endfunction

  // Stage p0: combinational extension of the incoming immediate
  logic [OUT_W-1:0] ext_p0;
  assign ext_p0 = extend(in_imm, in_mode);

  // Stage p1: output register plus skid slot
  logic             out_vld_p1;
  logic [OUT_W-1:0] out_data_p1;
  logic             skid_vld_p1;
  logic [OUT_W-1:0] skid_data_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             in_fire;
  logic             out_fire;
  logic             load_out;

  assign in_ready  = !skid_vld_p1;
  assign in_fire   = in_valid && !skid_vld_p1;
  assign out_fire  = out_vld_p1 && out_ready;
  assign load_out  = !out_vld_p1 || out_fire;
  assign out_valid = out_vld_p1;
  assign out_data  = out_data_p1;
  assign xfer_cnt  = cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
      skid_vld_p1 <= 1'b0;
      cnt_p1      <= '0;
    end else begin
      if (out_fire) cnt_p1 <= cnt_p1 + CNT_W'(1);
      if (load_out) begin
        // A full skid always refills the output slot before new input can.
        if (skid_vld_p1) begin
          out_data_p1 <= skid_data_p1;
          out_vld_p1  <= 1'b1;
          skid_vld_p1 <= 1'b0;
        end else if (in_fire) begin
          out_data_p1 <= ext_p0;
          out_vld_p1  <= 1'b1;
        end else begin
          out_vld_p1  <= 1'b0;
        end
      end else if (in_fire) begin
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire && !load_out) skid_data_p1 <= ext_p0;
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed and randomized checks for imm_ext_pipe at default, wide and
// narrow-counter parameterisations.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [15:0] xfer_cnt;

  logic        c_in_ready;
  logic        c_out_valid;
  logic [7:0]  c_out_data;
  logic [3:0]  c_xfer_cnt;

  logic        w_valid = 1'b0;
  logic        w_in_ready;
  logic [11:0] w_imm = '0;
  logic [1:0]  w_mode = '0;
  logic        w_out_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_data;
  logic [15:0] w_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_ext_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt)
  );

  imm_ext_pipe #(.CNT_W(4)) u_cnt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_data(c_out_data), .xfer_cnt(c_xfer_cnt)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(32), .SHIFT(2)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_in_ready),
    .in_imm(w_imm), .in_mode(w_mode), .out_valid(w_out_valid),
    .out_ready(w_ready), .out_data(w_data), .xfer_cnt(w_cnt)
  );

  function automatic logic [7:0] exp8(input logic [2:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   return {{5{imm[2]}}, imm};
      2'b01:   return {5'b00000, imm};
      2'b10:   return {{4{imm[2]}}, imm, 1'b0};
      default: return {imm, 5'b00000};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    w_valid  = 1'b0;
    rst_n    = 1'b0;
    step();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (xfer_cnt !== 16'h0) begin errors++; $display("FAIL reset_xfer_cnt: got %h expected 0000", xfer_cnt); end
  endtask

  task automatic test_modes();
    logic [7:0] exps [4];
    exps[0] = 8'hFD; exps[1] = 8'h05; exps[2] = 8'hFA; exps[3] = 8'hA0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_imm    = 3'b101;
    for (int i = 0; i < 4; i++) begin
      in_mode = 2'(i);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== exps[i]) begin
        errors++; $display("FAIL modes_%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exps[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL modes_idle: got v=%b expected 0", out_valid); end
    checks++; if (xfer_cnt !== 16'd4) begin errors++; $display("FAIL modes_cnt: got %0d expected 4", xfer_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 3'b011;
    in_mode   = 2'b00;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b expected 1", in_ready); end
    in_imm = 3'b100;
    step();
    in_valid = 1'b0;
    in_imm   = 3'b111;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin
      errors++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=03", out_valid, out_data);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_comb: got %b expected 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hFC) begin
      errors++; $display("FAIL bp_second: got v=%b d=%h expected v=1 d=fc", out_valid, out_data);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 3'b011;
    in_mode   = 2'b00;
    step();
    in_imm = 3'b100;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_full: got %b expected 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready: got %b expected 1", in_ready); end
    checks++; if (xfer_cnt !== 16'h0) begin errors++; $display("FAIL ar_xfer_cnt: got %h expected 0000", xfer_cnt); end
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_imm    = 3'b110;
    in_mode   = 2'b01;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h06) begin
      errors++; $display("FAIL ar_first: got v=%b d=%h expected v=1 d=06", out_valid, out_data);
    end
    step();
    checks++; if (out_valid !== 1'b0 || xfer_cnt !== 16'd1) begin
      errors++; $display("FAIL ar_alone: got v=%b cnt=%0d expected v=0 cnt=1", out_valid, xfer_cnt);
    end
  endtask

  task automatic test_wide();
    logic [1:0]  modes [4];
    logic [31:0] exps [4];
    modes[0] = 2'b00; exps[0] = 32'hFFFFF800;
    modes[1] = 2'b10; exps[1] = 32'hFFFFE000;
    modes[2] = 2'b11; exps[2] = 32'h80000000;
    modes[3] = 2'b01; exps[3] = 32'h00000800;
    w_ready = 1'b1;
    w_valid = 1'b1;
    w_imm   = 12'h800;
    for (int i = 0; i < 4; i++) begin
      w_mode = modes[i];
      step();
      checks++; if (w_out_valid !== 1'b1 || w_data !== exps[i]) begin
        errors++; $display("FAIL wide_%0d: got v=%b d=%h expected v=1 d=%h", i, w_out_valid, w_data, exps[i]);
      end
    end
    w_valid = 1'b0;
  endtask

  task automatic test_cnt_wrap();
    int n;
    logic drn;
    do_reset();
    n = 0;
    out_ready = 1'b1;
    in_imm    = 3'b010;
    in_mode   = 2'b00;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 17);
      drn = c_out_valid && out_ready;
      step();
      if (drn) begin
        n++;
        if (n == 15) begin checks++; if (c_xfer_cnt !== 4'hF) begin errors++; $display("FAIL wrap_15: got %h expected f", c_xfer_cnt); end end
        if (n == 16) begin checks++; if (c_xfer_cnt !== 4'h0) begin errors++; $display("FAIL wrap_16: got %h expected 0", c_xfer_cnt); end end
        if (n == 17) begin checks++; if (c_xfer_cnt !== 4'h1) begin errors++; $display("FAIL wrap_17: got %h expected 1", c_xfer_cnt); end end
      end
    end
    checks++; if (n != 17) begin errors++; $display("FAIL wrap_total: got %0d expected 17", n); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp_v;
    logic acc, drn, r0;
    int got, cycles, bad;
    got = 0; cycles = 0; bad = 0;
    do_reset();
    while (got < 10000 && cycles < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_imm    = 3'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      r0 = in_ready;
      out_ready = ~out_ready;
      #1;
      if (in_ready !== r0) begin
        bad++; errors++; $display("FAIL rnd_ready_comb: got %b expected %b", in_ready, r0);
      end
      out_ready = ~out_ready;
      #1;
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra: got %h expected nothing", out_data);
        end else begin
          exp_v = q.pop_front();
          if (out_data !== exp_v) begin errors++; $display("FAIL rnd_data: got %h expected %h", out_data, exp_v); end
        end
        got++;
      end
      if (acc) q.push_back(exp8(in_imm, in_mode));
      step();
      cycles++;
      checks++; if (out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid: got %b expected %b", out_valid, (q.size() != 0));
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_ready_comb_total: got %0d expected 0", bad); end
    checks++; if (got < 10000) begin errors++; $display("FAIL rnd_budget: got %0d expected 10000", got); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_async_reset();
    test_wide();
    test_cnt_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the datapath. Successor to the fixed 3-to-8 sign extender.
- Accepts an IN_W-bit immediate plus a 2-bit mode over a valid/ready handshake. Produces an OUT_W-bit extended, shifted or upper-placed operand.
- Contains a one-deep skid buffer, so the decode stage is never stalled combinationally by execute-side backpressure.
- Sits between the instruction-decode and ALU operand-select stages.

Parameters:
- IN_W, 3, immediate input width; legal range 1 <= IN_W < OUT_W.
- OUT_W, 8, extended output width.
- SHIFT, 1, left-shift amount for mode SXS; legal range 0 <= SHIFT <= OUT_W-IN_W.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream immediate valid.
- in_ready  output  1  unit can accept an input this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  00=SX sign-extend, 01=ZX zero-extend, 10=SXS sign-extend then shift left SHIFT, 11=UP place imm in MSBs, zero-fill LSBs.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  OUT_W  extended operand.
- xfer_cnt  output  CNT_W  number of completed output handshakes, wrapping.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, skid empty, in_ready=1, xfer_cnt=0. Reset asserted mid-operation discards all held entries immediately. First accept is possible on the first rising edge after rst_n deasserts.
- Handshakes:
  - Input transfer when in_valid && in_ready at a rising edge.
  - Output transfer when out_valid && out_ready.
  - in_ready = !skid_full, a register-only function. It has no combinational path from out_ready.
- Extension is computed combinationally on the input side and registered. Only the extended value and never the raw immediate is stored, in both the output register and the skid. Width rules:
  - SX: {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
  - ZX: zero-filled to OUT_W.
  - SXS: (SX result) << SHIFT, truncated to OUT_W. Bits shifted out are dropped. No overflow flag.
  - UP: {imm, (OUT_W-IN_W){1'b0}}.
- Latency: an accepted input appears on out_data with out_valid=1 on the next rising edge if the output register is empty or being drained that cycle. Throughput is one result per cycle while out_ready=1.
- Datapath state (two slots: output register O, skid S):
  - EMPTY (O empty, S empty): an input transfer loads O -> ONE.
  - ONE (O full, S empty):
    - input and output transfer together: O <= new, stay ONE.
    - input only: S <= new -> FULL.
    - output only -> EMPTY.
  - FULL (O full, S full): in_ready=0.
    - output transfer: O <= S, S empty -> ONE.
    - Inputs are ignored while in_ready=0.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- out_data is held stable while out_valid && !out_ready. Changes to in_imm/in_mode do not affect stored entries.
- out_data keeps its last value when out_valid falls; it is don't-care for checking.
- xfer_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Illegal parameters (IN_W >= OUT_W, or SHIFT > OUT_W-IN_W) are an elaboration error.

Test Plan:
- Defaults, out_ready=1, send imm=3'b101 in modes SX, ZX, SXS, UP on consecutive cycles -> out_data 8'hFD, 8'h05, 8'hFA, 8'hA0 on the following consecutive cycles, out_valid continuous, xfer_cnt=4.
- out_ready=0, send imm 3'b011 (SX) then 3'b100 (SX) -> after two accepts in_ready=0, out_data=8'h03 held. Raise out_ready -> 8'h03, then 8'hFC. in_ready returns to 1 the cycle after the first drain.
- Random in_valid/out_ready (10k transfers, all modes) against a reference-model queue -> exact order and values, no loss or duplication, in_ready never depends combinationally on out_ready.
- Assert rst_n low asynchronously (between clock edges) while in state FULL -> out_valid=0, in_ready=1, xfer_cnt=0 immediately; the first post-reset input emerges alone with correct value.
- IN_W=12, OUT_W=32, SHIFT=2, imm=12'h800: SX -> 32'hFFFFF800, SXS -> 32'hFFFFE000, UP -> 32'h80000000, ZX -> 32'h00000800.
- CNT_W=4, 17 output transfers -> xfer_cnt reads 0xF after 15, 0x0 after 16, 0x1 after 17.
